// File: rtl/m6850_acia.sv
// m6850_acia: simplified 6850-style ACIA with a fixed 8N1 frame and a fixed bit-rate divider.
// Ports:
//   CLK_1  system clock, all state changes on posedge
//   RESET  synchronous active-high reset
//   CS     chip select; RS register select; R_W 1=read 0=write
//   D      bidirectional data bus, driven only while CS & R_W
//   RXD    asynchronous serial input (idle high)
//   TXD    serial output (idle high)
//   _IRQ   active-low interrupt request, registered
module m6850_acia #(
  parameter int unsigned DIV = 16
) (
  input  logic       CLK_1,
  input  logic       RESET,
  input  logic       CS,
  input  logic       RS,
  input  logic       R_W,
  inout  wire  [7:0] D,
  input  logic       RXD,
  output logic       TXD,
  output logic       _IRQ
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START_CHK, RX_DATA, RX_STOP} rx_state_e;

  // Only RIE and TIE of the control register have any observable effect.
  logic             rie_q, tie_q, irq_n_q;
  logic [7:0]       tdr_q, tx_shift_q;
  logic             tdre_q, txd_q;
  tx_state_e        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;

  logic             rx_s1_q, rx_s2_q;
  rx_state_e        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q, rdr_q;
  logic             rdrf_q, fe_q, ovrn_q;

  logic             wr_ctrl, wr_tdr, rd_rdr, soft_rst, do_reset, irq_d;
  logic [7:0]       rd_data;

  // Bus decode; a control write with bits 1:0 = 11 acts exactly like RESET.
  assign wr_ctrl  = CS & ~R_W & ~RS;
  assign wr_tdr   = CS & ~R_W &  RS;
  assign rd_rdr   = CS &  R_W &  RS;
  assign soft_rst = wr_ctrl & (D[1:0] == 2'b11);
  assign do_reset = RESET | soft_rst;

  assign irq_d   = (rie_q & (rdrf_q | ovrn_q)) | (tie_q & tdre_q);
  assign rd_data = RS ? rdr_q : {irq_d, 1'b0, ovrn_q, fe_q, 2'b00, tdre_q, rdrf_q};
  assign D       = (CS & R_W) ? rd_data : 8'hzz;
  assign TXD     = txd_q;
  assign _IRQ    = irq_n_q;

  // Control bits and registered interrupt line.
  always_ff @(posedge CLK_1) begin
    if (do_reset) begin
      rie_q   <= 1'b0;
      tie_q   <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      if (wr_ctrl) begin
        rie_q <= D[7];
        tie_q <= D[5];
      end
      irq_n_q <= ~irq_d;
    end
  end

  // Transmit holding register and frame FSM.
  always_ff @(posedge CLK_1) begin
    if (do_reset) begin
      tx_state_q <= TX_IDLE;
      txd_q      <= 1'b1;
      tdre_q     <= 1'b1;
      tdr_q      <= 8'h00;
      tx_shift_q <= 8'h00;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
    end else begin
      // Uses the pre-edge TDRE, so a write colliding with a TDR transfer is dropped.
      if (wr_tdr && tdre_q) begin
        tdr_q  <= D;
        tdre_q <= 1'b0;
      end
      case (tx_state_q)
        TX_IDLE: begin
          if (!tdre_q) begin
            tx_shift_q <= tdr_q;
            tdre_q     <= 1'b1;
            txd_q      <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            txd_q      <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              txd_q      <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q <= '0;
            // Pending byte starts the next frame with no idle gap.
            if (!tdre_q) begin
              tx_shift_q <= tdr_q;
              tdre_q     <= 1'b1;
              txd_q      <= 1'b0;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // Receive synchronizer, frame FSM and receive status flags.
  always_ff @(posedge CLK_1) begin
    if (do_reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rdr_q      <= 8'h00;
      rdrf_q     <= 1'b0;
      fe_q       <= 1'b0;
      ovrn_q     <= 1'b0;
    end else begin
      rx_s1_q <= RXD;
      rx_s2_q <= rx_s1_q;
      if (rd_rdr) begin
        rdrf_q <= 1'b0;
        ovrn_q <= 1'b0;
      end
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s2_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START_CHK;
          end
        end
        RX_START_CHK: begin
          if (rx_cnt_q == CNT_HALF) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            // A same-cycle RDR read frees the buffer, so the transfer wins over overrun.
            if (!rdrf_q || rd_rdr) begin
              rdr_q  <= rx_shift_q;
              rdrf_q <= 1'b1;
              fe_q   <= ~rx_s2_q;
            end else begin
              ovrn_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m6850_acia.sv
module tb_m6850_acia;

  localparam int unsigned DIV = 4;

  logic       clk;
  logic       rst, cs, rs, rw, rxd;
  logic       txd, irq_n;
  logic       tb_en;
  logic [7:0] tb_drv;
  wire  [7:0] d_bus;

  int checks = 0;
  int errors = 0;

  logic       txq[$];
  logic [7:0] rxq[$];

  assign d_bus = tb_en ? tb_drv : 8'hzz;

  m6850_acia #(.DIV(DIV)) dut (
    .CLK_1(clk),
    .RESET(rst),
    .CS   (cs),
    .RS   (rs),
    .R_W  (rw),
    .D    (d_bus),
    .RXD  (rxd),
    .TXD  (txd),
    ._IRQ (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // All bus tasks are entered on a negedge and return on a later negedge.
  task automatic bus_write(input logic sel, input logic [7:0] val);
    cs = 1'b1; rw = 1'b0; rs = sel; tb_en = 1'b1; tb_drv = val;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1; tb_en = 1'b0;
  endtask

  task automatic bus_read(input logic sel, output logic [7:0] val);
    cs = 1'b1; rw = 1'b1; rs = sel;
    #1 val = d_bus;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic expect_status(input logic [7:0] exp, input string name);
    logic [7:0] s;
    bus_read(1'b0, s);
    checks++;
    if (s !== exp) begin
      errors++;
      $display("FAIL %s: status got %h expected %h", name, s, exp);
    end
  endtask

  task automatic expect_rx_read(input string name);
    logic [7:0] got;
    logic [7:0] exp;
    bus_read(1'b1, got);
    checks++;
    if (rxq.size() == 0) begin
      errors++;
      $display("FAIL %s: rx data %h read but scoreboard empty", name, got);
    end else begin
      exp = rxq.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: rx data got %h expected %h", name, got, exp);
      end
    end
  endtask

  task automatic expect_irq(input logic exp, input string name);
    checks++;
    if (irq_n !== exp) begin
      errors++;
      $display("FAIL %s: _IRQ got %b expected %b", name, irq_n, exp);
    end
  endtask

  function automatic void push_tx_frame(input logic [7:0] b);
    for (int k = 0; k < int'(DIV); k++) txq.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < int'(DIV); k++) txq.push_back(b[i]);
    for (int k = 0; k < int'(DIV); k++) txq.push_back(1'b1);
  endfunction

  // Compare TXD against the scoreboard for n cycles; optional TX write at cycle wr_at.
  task automatic run_tx(input int n, input int wr_at, input logic [7:0] wr_val, input string name);
    logic exp;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (txq.size() == 0) begin
        errors++;
        $display("FAIL %s: cycle %0d txd %b but scoreboard empty", name, i, txd);
      end else begin
        exp = txq.pop_front();
        if (txd !== exp) begin
          errors++;
          $display("FAIL %s: cycle %0d txd got %b expected %b", name, i, txd, exp);
        end
      end
      if (i == wr_at) begin
        cs = 1'b1; rw = 1'b0; rs = 1'b1; tb_en = 1'b1; tb_drv = wr_val;
        push_tx_frame(wr_val);
      end else if (i == wr_at + 1) begin
        cs = 1'b0; rw = 1'b1; tb_en = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Poll status until bit idx sets; irq_seen is _IRQ at the poll that first saw it.
  task automatic wait_flag(input int idx, input string name, output logic irq_seen);
    logic [7:0] s;
    logic found;
    found = 1'b0;
    irq_seen = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      irq_seen = irq_n;
      bus_read(1'b0, s);
      if (s[idx]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: status bit %0d got 0 expected 1 within 30 cycles", name, idx);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cs = 1'b0; rw = 1'b1; rs = 1'b0; rxd = 1'b1; tb_en = 1'b0; tb_drv = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
    expect_irq(1'b1, "reset_irq");
    // DUT must not drive D while CS=0, so the bench's own value must read back intact.
    tb_en = 1'b1; tb_drv = 8'hA5;
    #1;
    checks++;
    if (d_bus !== 8'hA5) begin errors++; $display("FAIL reset_hiz: D got %h expected %h", d_bus, 8'hA5); end
    tb_en = 1'b0;
    @(negedge clk);
    expect_status(8'h02, "reset_status");
  endtask

  task automatic test_tx_frame;
    bus_write(1'b1, 8'hA5);
    push_tx_frame(8'hA5);
    expect_status(8'h00, "tx_tdre_low");
    run_tx(80, 5, 8'h5A, "tx_back_to_back");
    checks++;
    if (txq.size() != 0) begin errors++; $display("FAIL tx_sb_drain: %0d left expected 0", txq.size()); end
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL tx_idle: txd got %b expected 1", txd); end
    expect_status(8'h02, "tx_done_status");
  endtask

  task automatic test_write_ignored;
    bus_write(1'b1, 8'h0F);
    push_tx_frame(8'h0F);
    bus_write(1'b1, 8'hF0);
    for (int k = 0; k < 12; k++) txq.push_back(1'b1);
    run_tx(52, -5, 8'h00, "tx_write_ignored");
  endtask

  task automatic test_rx_frame;
    logic irq_seen;
    rxq.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_flag(0, "rx_rdrf", irq_seen);
    expect_status(8'h03, "rx_status_full");
    expect_rx_read("rx_data");
    expect_status(8'h02, "rx_status_empty");
    rxq.push_back(8'h81);
    send_frame(8'h81, 1'b0);
    wait_flag(0, "rx_fe_rdrf", irq_seen);
    expect_status(8'h13, "rx_fe_status");
    expect_rx_read("rx_fe_data");
    expect_status(8'h12, "rx_fe_sticky");
    repeat (8) @(negedge clk);
  endtask

  task automatic test_overrun;
    logic irq_seen;
    rxq.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    wait_flag(0, "ovr_first", irq_seen);
    send_frame(8'h22, 1'b1);
    wait_flag(5, "ovr_flag", irq_seen);
    expect_status(8'h23, "ovr_status");
    expect_rx_read("ovr_data");
    expect_status(8'h02, "ovr_cleared");
  endtask

  task automatic test_irq;
    logic irq_seen;
    bus_write(1'b0, 8'h80);
    @(negedge clk);
    expect_irq(1'b1, "irq_rie_idle");
    rxq.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_flag(0, "irq_rdrf", irq_seen);
    checks++;
    if (irq_seen !== 1'b1) begin errors++; $display("FAIL irq_latency: _IRQ got %b expected 1", irq_seen); end
    expect_irq(1'b0, "irq_assert");
    expect_status(8'h83, "irq_status");
    expect_rx_read("irq_data");
    expect_irq(1'b0, "irq_hold");
    @(negedge clk);
    expect_irq(1'b1, "irq_release");
    bus_write(1'b0, 8'h20);
    @(negedge clk);
    expect_irq(1'b0, "irq_tie");
    bus_write(1'b0, 8'h00);
    @(negedge clk);
    expect_irq(1'b1, "irq_off");
  endtask

  task automatic test_noise;
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    expect_status(8'h02, "noise_no_rdrf");
  endtask

  task automatic test_master_reset;
    int ones;
    bus_write(1'b1, 8'h40);
    push_tx_frame(8'h40);
    @(negedge clk);
    run_tx(10, -5, 8'h00, "mr_frame_start");
    txq.delete();
    bus_write(1'b0, 8'h03);
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL mr_txd: got %b expected 1", txd); end
    expect_status(8'h02, "mr_status");
    ones = 0;
    for (int i = 0; i < 50; i++) begin
      if (txd === 1'b1) ones++;
      @(negedge clk);
    end
    checks++;
    if (ones != 50) begin errors++; $display("FAIL mr_abandon: txd high %0d of 50 cycles expected 50", ones); end
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; rw = 1'b1; rs = 1'b0; rxd = 1'b1; tb_en = 1'b0; tb_drv = 8'h00;
    @(negedge clk);
    test_reset();
    test_tx_frame();
    test_write_ignored();
    test_rx_frame();
    test_overrun();
    test_irq();
    test_noise();
    test_master_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m6850_acia.md
Name: m6850_acia

Overview:
- Simplified Motorola 6850-style serial interface (ACIA), memory-mapped on the m6800 data bus.
- The CPU writes bytes for transmission and reads received bytes and status over D[7:0].
- Its active-low interrupt output drives the CPU's _IRQ input directly.
- Fixed 8N1 frame format (8 data bits, no parity, 1 stop bit). The bit rate is derived from CLK_1 by a fixed divider.

Parameters:
DIV, 16, CLK_1 cycles per serial bit; even, >= 4

Ports:
CLK_1  input  1  system clock; all state updates on posedge
RESET  input  1  synchronous, active-high reset
CS     input  1  chip select, active high; one bus access per CLK_1 cycle with CS=1
RS     input  1  register select: 0 = control (write) / status (read), 1 = TX data (write) / RX data (read)
R_W    input  1  1 = read, 0 = write
D      inout  8  data bus; driven only when CS=1 and R_W=1, otherwise high-Z
RXD    input  1  serial receive line, asynchronous, idle high
TXD    output 1  serial transmit line, idle high
_IRQ   output 1  interrupt request, active low

Behaviour:
Interface decision: single clock CLK_1; RESET is synchronous and active-high.

Reset:
- On RESET=1 at a posedge: TXD=1, _IRQ=1, control register=0, TDRE=1, RDRF=0, FE=0, OVRN=0.
- TX and RX state machines return to IDLE. Any in-flight frame is abandoned and TXD is forced to 1 immediately.
- D is high-Z during and after reset until a read cycle.

Register map:
- Control, write RS=0:
  - bit7 RIE: receive interrupt enable.
  - bit5 TIE: transmit interrupt enable.
  - bits1:0 = 11 is a software master reset: same effect as RESET, and the control register is left at 0.
  - All other control bits are stored but have no function.
- Status, read RS=0: {IRQ, 1'b0, OVRN, FE, 2'b0, TDRE, RDRF}, bit7 down to bit0. Reading status has no side effects.
- TX data, write RS=1:
  - If TDRE=1: byte loads into TDR and TDRE becomes 0.
  - If TDRE=0: the write is ignored and TDR is unchanged.
- RX data, read RS=1: returns RDR. RDRF and OVRN clear at the end of that cycle.

Read timing: D is combinational from register state while CS&R_W. Side effects apply at the posedge ending the access.

Interrupt: IRQ = (RIE & (RDRF | OVRN)) | (TIE & TDRE). _IRQ = ~IRQ, registered, so it updates one cycle after the flags change.

Transmitter FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: when TDR is full, TDR moves to the shift register on the next posedge and TDRE becomes 1 in that same cycle.
- START: TXD=0 for DIV cycles.
- DATA: 8 bits, LSB first, DIV cycles each.
- STOP: TXD=1 for DIV cycles.
- Frame length is exactly 10*DIV cycles. Its first start-bit cycle is the cycle after the transfer.
- If TDR is full at the end of STOP, the next START follows with no idle gap (back-to-back frames).

Receiver:
- RXD passes through a 2-flop synchronizer before use (2-cycle input latency).
- FSM: IDLE -> START_CHK -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized 0 enters START_CHK.
  - START_CHK: after DIV/2 cycles, sample RXD. If 1, it was a false start; return to IDLE with no flag change. If 0, go to DATA.
  - DATA: 8 samples at DIV intervals, LSB first.
  - STOP: 1 sample DIV cycles after the last data sample.
- On the stop sample:
  - If RDRF=0: RDR = data, RDRF = 1, FE = (stop bit == 0).
  - If RDRF=1: OVRN = 1; RDR and FE are unchanged; the new byte is discarded.
- After STOP the receiver returns to IDLE immediately. A low line then re-arms start detection.

Simultaneous events:
- Stop-sample transfer in the same cycle as an RX data read: the read returns the old RDR. The transfer wins, so RDRF stays 1 with the new byte and OVRN is not set.
- TX data write in the same cycle TDR moves to the shift register: the write sees TDRE=0 and is ignored.
- Master-reset control write during a frame: behaves as RESET.

Test Plan:
(DIV=4 for all cases.)
- Reset: RESET=1 for 2 cycles, then read status -> D=8'h02 (TDRE=1), TXD=1, _IRQ=1, D high-Z when CS=0.
- TX frame: write 8'hA5 to RS=1 -> TDRE=0 for 1 cycle then 1. TXD over 40 cycles = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles. Back-to-back second write yields a contiguous second frame with no gap.
- RX frame: drive 8'h3C as 8N1 on RXD at 4 cycles/bit -> RDRF=1 after the stop sample. RX data read returns 8'h3C and the next status shows RDRF=0. A stop bit driven 0 sets FE=1.
- Overrun: receive 8'h11 then 8'h22 without reading -> OVRN=1 and RDR=8'h11. Reading RX data returns 8'h11 and clears RDRF and OVRN.
- Interrupts: write control 8'h80, then receive a byte -> _IRQ goes 0 one cycle after RDRF sets and returns to 1 after the RX read. Write control 8'h20 with TX idle -> _IRQ=0.
- Noise/reset: a 1-cycle RXD low pulse gives no RDRF. A control write of 8'h03 mid-TX frame gives TXD=1 next cycle and status 8'h02.
